// File: rtl/pool_layer_sequencer.sv
// pool_layer_sequencer: walks NUM_CH feature-map channels through a maxpool
// engine one at a time. For each channel it supplies the input SRAM base
// address, launches the engine, gates and counts output SRAM writes, and
// guards against short or long channels and against a hung engine.
module pool_layer_sequencer #(
   parameter int NUM_CH   = 4,
   parameter int IN_SIZE  = 36,
   parameter int OUT_SIZE = 9,
   parameter int TIMEOUT  = 1023,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int IN_AW   = (NUM_CH * IN_SIZE > 1) ? $clog2(NUM_CH * IN_SIZE) : 1,
   localparam int OUT_AW  = (NUM_CH * OUT_SIZE > 1) ? $clog2(NUM_CH * OUT_SIZE) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CH_W-1:0]   ch_idx,
   output logic              eng_start,
   input  logic              eng_done,
   output logic [IN_AW-1:0]  in_base,
   input  logic              eng_wr_valid,
   output logic              out_wr_en,
   output logic [OUT_AW-1:0] out_addr
);

   // Write counter must hold OUT_SIZE itself so a full channel is distinguishable
   // from an overflow attempt; the timer must be able to reach TIMEOUT.
   localparam int WR_W  = $clog2(OUT_SIZE + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
      S_NEXT   = 3'd3,
      S_FINISH = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
   logic [WR_W-1:0]   wr_cnt_q, wr_cnt_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              ovf_q, ovf_d;
   logic              err_q, err_d;
   logic              wr_fire;

   // A write reaches the output SRAM only while running and below quota.
   assign wr_fire = eng_wr_valid && (state_q == S_RUN) && (wr_cnt_q < WR_W'(OUT_SIZE));

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ch_idx_q <= '0;
         wr_cnt_q <= '0;
         timer_q  <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_idx_q <= ch_idx_d;
         wr_cnt_q <= wr_cnt_d;
         timer_q  <= timer_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic; abort overrides every other transition outside IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_LAUNCH;
         S_LAUNCH: state_d = S_RUN;
         S_RUN: begin
            // eng_done wins over a timeout landing on the same cycle.
            if (eng_done)                             state_d = S_NEXT;
            else if (timer_q == TMR_W'(TIMEOUT - 1))  state_d = S_ERR;
         end
         S_NEXT: begin
            if ((wr_cnt_q != WR_W'(OUT_SIZE)) || ovf_q) state_d = S_ERR;
            else if (ch_idx_q == CH_W'(NUM_CH - 1))     state_d = S_FINISH;
            else                                        state_d = S_LAUNCH;
         end
         S_FINISH: state_d = S_IDLE;
         S_ERR:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
   end

   // Channel index, write counter, watchdog timer, overflow and sticky error updates.
   always_comb begin
      ch_idx_d = ch_idx_q;
      wr_cnt_d = wr_cnt_q;
      timer_d  = timer_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ch_idx_d = '0;
               wr_cnt_d = '0;
               timer_d  = '0;
               ovf_d    = 1'b0;
               err_d    = 1'b0;
            end
         end
         S_LAUNCH: begin
            wr_cnt_d = '0;
            timer_d  = '0;
            ovf_d    = 1'b0;
         end
         S_RUN: begin
            timer_d = timer_q + TMR_W'(1);
            if (wr_fire) wr_cnt_d = wr_cnt_q + WR_W'(1);
            if (eng_wr_valid && (wr_cnt_q == WR_W'(OUT_SIZE))) ovf_d = 1'b1;
         end
         S_NEXT: begin
            if (state_d == S_LAUNCH) ch_idx_d = ch_idx_q + CH_W'(1);
         end
         default: ;
      endcase
      // err is raised on entry so it is already valid in the done cycle.
      if (state_d == S_ERR) err_d = 1'b1;
   end

   // Outputs decoded from registered state; addresses come only from registers.
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_FINISH) || (state_q == S_ERR);
      eng_start = (state_q == S_LAUNCH);
      out_wr_en = wr_fire;
      err       = err_q;
      ch_idx    = ch_idx_q;
      in_base   = IN_AW'(ch_idx_q) * IN_AW'(IN_SIZE);
      out_addr  = OUT_AW'(ch_idx_q) * OUT_AW'(OUT_SIZE) + OUT_AW'(wr_cnt_q);
   end

endmodule

// File: tb/tb_pool_layer_sequencer.sv
// Testbench for pool_layer_sequencer: table of whole-layer runs driven by a
// reactive engine model, plus hand sequences for timeout, abort, ignored
// start and reset mid-run.
module tb_pool_layer_sequencer;

   localparam int NUM_CH   = 4;
   localparam int IN_SIZE  = 36;
   localparam int OUT_SIZE = 9;
   localparam int TIMEOUT  = 20;
   localparam int CH_W     = 2;
   localparam int IN_AW    = 8;
   localparam int OUT_AW   = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              eng_done = 1'b0;
   logic              eng_wr_valid = 1'b0;
   logic              busy, done, err, eng_start, out_wr_en;
   logic [CH_W-1:0]   ch_idx;
   logic [IN_AW-1:0]  in_base;
   logic [OUT_AW-1:0] out_addr;

   always #5 clk = ~clk;

   pool_layer_sequencer #(
      .NUM_CH(NUM_CH), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .done(done), .err(err), .ch_idx(ch_idx),
      .eng_start(eng_start), .eng_done(eng_done), .in_base(in_base),
      .eng_wr_valid(eng_wr_valid), .out_wr_en(out_wr_en), .out_addr(out_addr)
   );

   typedef struct {
      logic [3:0][7:0] w;        // writes emitted per channel, w[c] for channel c
      bit              coin;     // last write coincides with eng_done
      int              exp_starts;
      bit              exp_err;
      int              exp_writes;
   } vec_t;

   vec_t vecs[7];

   int n_checks = 0;
   int n_errors = 0;
   int n_eng_start, n_done, n_writes, cur_w, done_err, first_launch_err;
   int wr_hits[NUM_CH*OUT_SIZE];
   logic s_eng_start, s_done, s_busy, s_err;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic clear_acc();
      n_eng_start = 0;
      n_done = 0;
      n_writes = 0;
      cur_w = 0;
      done_err = -1;
      first_launch_err = -1;
      for (int i = 0; i < NUM_CH*OUT_SIZE; i++) wr_hits[i] = 0;
   endtask

   // One clock: sample outputs at the falling edge, then step past the rising edge.
   task automatic cyc();
      @(negedge clk);
      s_eng_start = eng_start;
      s_done = done;
      s_busy = busy;
      s_err = err;
      if (eng_start) begin
         check("launch_ch", 32'(ch_idx), n_eng_start);
         check("launch_base", 32'(in_base), n_eng_start * IN_SIZE);
         if (n_eng_start == 0) first_launch_err = int'(err);
         n_eng_start++;
         cur_w = 0;
      end
      if (out_wr_en) begin
         check("wr_addr", 32'(out_addr), (n_eng_start - 1) * OUT_SIZE + cur_w);
         if (int'(out_addr) < NUM_CH*OUT_SIZE) wr_hits[out_addr]++;
         cur_w++;
         n_writes++;
      end
      if (done) begin
         n_done++;
         done_err = int'(err);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_launch_or_done(output bit launched);
      bit got;
      launched = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
         cyc();
         if (s_eng_start) begin
            launched = 1'b1;
            got = 1'b1;
         end else if (s_done) begin
            got = 1'b1;
         end
      end
      check("event_wait", 32'(got), 1);
   endtask

   task automatic drive_channel(input int nw, input bit coin);
      for (int k = 0; k < nw; k++) begin
         eng_wr_valid = 1'b1;
         eng_done = coin && (k == nw - 1);
         cyc();
      end
      eng_wr_valid = 1'b0;
      if (!coin || nw == 0) begin
         eng_done = 1'b1;
         cyc();
      end
      eng_done = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_eng_start"}, 32'(eng_start), 0);
      check({tag, "_out_wr_en"}, 32'(out_wr_en), 0);
      check({tag, "_ch_idx"}, 32'(ch_idx), 0);
      check({tag, "_in_base"}, 32'(in_base), 0);
      check({tag, "_out_addr"}, 32'(out_addr), 0);
   endtask

   task automatic run_layer(input int id, input vec_t v);
      bit l;
      bit fin;
      int bad;
      clear_acc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      fin = 1'b0;
      for (int c = 0; c < NUM_CH && !fin; c++) begin
         wait_launch_or_done(l);
         if (!l) fin = 1'b1;
         else drive_channel(int'(v.w[c]), v.coin);
      end
      if (!fin) begin
         wait_launch_or_done(l);
         check("extra_launch", 32'(l), 0);
      end
      cyc();
      cyc();
      check("run_starts", n_eng_start, v.exp_starts);
      check("run_done_cnt", n_done, 1);
      check("run_err", done_err, 32'(v.exp_err));
      check("run_writes", n_writes, v.exp_writes);
      check("run_err_cleared", first_launch_err, 0);
      check("run_idle", 32'(s_busy), 0);
      if (!v.exp_err) begin
         bad = 0;
         for (int a = 0; a < NUM_CH*OUT_SIZE; a++) if (wr_hits[a] != 1) bad++;
         check("addr_map_bad", bad, 0);
      end
      $display("run %0d: starts=%0d writes=%0d done=%0d err=%0d", id, n_eng_start, n_writes, n_done, done_err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit l;
      bit got;
      int cnt;

      vecs[0] = '{w: {8'd9, 8'd9, 8'd9, 8'd9},  coin: 1'b0, exp_starts: 4, exp_err: 1'b0, exp_writes: 36};
      vecs[1] = '{w: {8'd9, 8'd8, 8'd9, 8'd9},  coin: 1'b0, exp_starts: 3, exp_err: 1'b1, exp_writes: 26};
      vecs[2] = '{w: {8'd9, 8'd9, 8'd9, 8'd9},  coin: 1'b1, exp_starts: 4, exp_err: 1'b0, exp_writes: 36};
      vecs[3] = '{w: {8'd9, 8'd9, 8'd9, 8'd10}, coin: 1'b0, exp_starts: 1, exp_err: 1'b1, exp_writes: 9};
      vecs[4] = '{w: {8'd9, 8'd9, 8'd9, 8'd0},  coin: 1'b0, exp_starts: 1, exp_err: 1'b1, exp_writes: 0};
      vecs[5] = '{w: {8'd8, 8'd9, 8'd9, 8'd9},  coin: 1'b1, exp_starts: 4, exp_err: 1'b1, exp_writes: 35};
      vecs[6] = '{w: {8'd9, 8'd9, 8'd9, 8'd9},  coin: 1'b0, exp_starts: 4, exp_err: 1'b0, exp_writes: 36};

      clear_acc();
      rst_n = 1'b0;
      repeat (3) cyc();
      check_reset_outputs("por");
      rst_n = 1'b1;
      cyc();

      for (int i = 0; i < 7; i++) run_layer(i, vecs[i]);

      // Hung engine: done/err must come after exactly TIMEOUT RUN cycles.
      clear_acc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_launch_or_done(l);
      check("to_launch", 32'(l), 1);
      cnt = 0;
      got = 1'b0;
      for (int t = 0; t < 60 && !got; t++) begin
         cyc();
         cnt++;
         if (s_done) got = 1'b1;
      end
      check("to_done_seen", 32'(got), 1);
      check("to_latency", cnt, TIMEOUT + 1);
      check("to_err", done_err, 1);
      check("to_starts", n_eng_start, 1);
      repeat (3) cyc();
      check("to_err_sticky", 32'(s_err), 1);
      $display("timeout: cycles_after_launch=%0d err=%0d", cnt, done_err);

      // Ignored start and abort during channel 1.
      clear_acc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_launch_or_done(l);
      drive_channel(9, 1'b0);
      wait_launch_or_done(l);
      check("ab_launch1", 32'(l), 1);
      eng_wr_valid = 1'b1;
      cyc();
      cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      eng_wr_valid = 1'b0;
      check("ign_start_ch", 32'(ch_idx), 1);
      check("ign_start_launches", n_eng_start, 2);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      repeat (4) cyc();
      check("abort_no_done", n_done, 0);
      check("abort_launches", n_eng_start, 2);
      check("abort_err", 32'(err), 0);
      check("abort_writes", n_writes, 13);
      $display("abort: launches=%0d writes=%0d done=%0d", n_eng_start, n_writes, n_done);

      // Reset during channel 3, then a clean run from channel 0.
      clear_acc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         wait_launch_or_done(l);
         drive_channel(9, 1'b0);
      end
      wait_launch_or_done(l);
      check("rst_launch3", 32'(l), 1);
      check("rst_ch3", 32'(ch_idx), 3);
      eng_wr_valid = 1'b1;
      cyc();
      cyc();
      eng_wr_valid = 1'b0;
      rst_n = 1'b0;
      cyc();
      check_reset_outputs("midrst");
      cyc();
      rst_n = 1'b1;
      cyc();
      check("midrst_no_done", n_done, 0);
      $display("reset mid-run: launches=%0d writes=%0d done=%0d", n_eng_start, n_writes, n_done);
      run_layer(7, vecs[0]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pool_layer_sequencer.md
POOL_LAYER_SEQUENCER -- requirements
Module: pool_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of feature-map channels pooled per layer run.
REQ-002 SHALL have parameter IN_SIZE, default 36, meaning input words per channel in the input SRAM.
REQ-003 SHALL have parameter OUT_SIZE, default 9, meaning pooled words expected per channel.
REQ-004 SHALL have parameter TIMEOUT, default 1023, meaning the maximum RUN cycles allowed per channel.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port start  input  1  request one layer run; sampled in IDLE only.
REQ-008 SHALL have port abort  input  1  cancel the run in progress.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of run, whether good or failed.
REQ-011 SHALL have port err  output  1  sticky failure flag, valid from done until next accepted start.
REQ-012 SHALL have port ch_idx  output  CH_W=max(1,clog2(NUM_CH))  channel currently being processed.
REQ-013 SHALL have port eng_start  output  1  one-cycle start pulse to the maxpool engine.
REQ-014 SHALL have port eng_done  input  1  engine completion pulse.
REQ-015 SHALL have port in_base  output  clog2(NUM_CH*IN_SIZE)  input SRAM base address = ch_idx*IN_SIZE.
REQ-016 SHALL have port eng_wr_valid  input  1  pooled/dropout word valid from the datapath.
REQ-017 SHALL have port out_wr_en  output  1  gated write enable to the output SRAM.
REQ-018 SHALL have port out_addr  output  clog2(NUM_CH*OUT_SIZE)  output SRAM address = ch_idx*OUT_SIZE + wr_cnt.

Function
REQ-019 SHALL implement the states IDLE, LAUNCH, RUN, NEXT, FINISH and ERR.
REQ-020 IDLE with start=1 SHALL clear err, set ch_idx=0 and go to LAUNCH; start outside IDLE SHALL be ignored.
REQ-021 LAUNCH SHALL drive eng_start=1 for exactly one cycle, clear wr_cnt and the timer, and go to RUN.
REQ-022 RUN SHALL increment the timer every cycle and go to NEXT on eng_done=1.
REQ-023 RUN SHALL go to ERR when the timer reaches TIMEOUT with eng_done=0; when eng_done and timeout coincide, eng_done SHALL win.
REQ-024 out_wr_en SHALL equal eng_wr_valid AND state==RUN AND wr_cnt<OUT_SIZE (combinational); each such write SHALL increment wr_cnt on that edge.
REQ-025 eng_wr_valid with wr_cnt==OUT_SIZE (overflow) SHALL suppress the write and set an internal overflow flag.
REQ-026 A write in the same cycle as eng_done SHALL be counted before the NEXT check.
REQ-027 NEXT with wr_cnt!=OUT_SIZE or overflow set SHALL go to ERR.
REQ-028 Otherwise NEXT SHALL go to FINISH if ch_idx==NUM_CH-1, else increment ch_idx and go to LAUNCH.
REQ-029 FINISH SHALL pulse done=1 with err=0 and return to IDLE.
REQ-030 ERR SHALL set err=1, pulse done=1 and return to IDLE; err SHALL hold until the next accepted start.
REQ-031 abort=1 in any non-IDLE state SHALL return to IDLE on the next edge without a done pulse and SHALL leave err unchanged; abort SHALL take priority over all other transitions.
REQ-032 in_base and out_addr SHALL be registered or derived from registered ch_idx/wr_cnt only, with no combinational path from inputs.
REQ-033 eng_wr_valid outside RUN SHALL be ignored.

Reset
REQ-034 With rst_n=0 at a clock edge, the block SHALL enter IDLE with busy=0, done=0, err=0, eng_start=0, out_wr_en=0, ch_idx=0, wr_cnt=0, timer=0 and the overflow flag clear.
REQ-035 Reset mid-run SHALL abandon the run with no done pulse.

Verification
REQ-036 Nominal: start; engine model emits 9 eng_wr_valid then eng_done per channel -> 4 eng_start pulses, out_addr 0..35 written once each, in_base 0/36/72/108, single done with err=0.
REQ-037 Short channel: channel 2 emits 8 writes then eng_done -> ERR, done with err=1, no eng_start for channel 3.
REQ-038 Overflow: channel 0 emits 10 writes -> 10th write has out_wr_en=0, then done with err=1.
REQ-039 Timeout: TIMEOUT=20; engine never asserts eng_done -> done and err=1 exactly 20 RUN cycles after eng_start.
REQ-040 Abort/start races: abort during channel 1 RUN -> IDLE next edge, no done; start during RUN ignored; last write coincident with eng_done is counted and passes.
REQ-041 Reset mid-run: rst_n=0 during channel 3 -> all outputs at reset values after the edge; a new start then runs from channel 0.
